// File: rtl/latch_q_edge_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : latch_q_edge_monitor
//  Brief    : Synchronises and debounces the asynchronous latch q output,
//             emits single-cycle rise/fall strobes, counts rising edges per
//             fixed window and hands each window count downstream over a
//             valid/ready handshake with sticky overwrite flag.
//  Revision : 1.0  initial release
// ============================================================================
module latch_q_edge_monitor #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8,
   parameter int WINDOW        = 64
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             lat_q,
   output logic             out_level,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic [CNT_W-1:0] cnt_data,
   output logic             cnt_ovf
);

   localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int WC_W = $clog2(WINDOW);

   localparam logic [SC_W-1:0]  SC_LAST = SC_W'(STABLE_CYCLES - 1);
   localparam logic [SC_W-1:0]  SC_ONE  = SC_W'(1);
   localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);
   localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_STABLE   = 1'b0,
      ST_CHANGING = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [SC_W-1:0]        sc_q, sc_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic [WC_W-1:0]        wcnt_q, wcnt_d;
   logic [CNT_W-1:0]       ecnt_q, ecnt_d;
   logic [CNT_W-1:0]       cnt_data_q, cnt_data_d;
   logic                   cnt_valid_q, cnt_valid_d;
   logic                   cnt_ovf_q, cnt_ovf_d;

   logic                   s;
   logic                   terminal;
   logic                   xfer;
   logic [CNT_W-1:0]       ecnt_inc;

   assign s = sync_q[SYNC_STAGES-1];

   // Shift the raw latch output through the synchroniser chain
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], lat_q};
   end

   // Debounce: a new level must be seen STABLE_CYCLES times in a row
   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         ST_STABLE: begin
            if (s != level_q) begin
               if (STABLE_CYCLES == 1) begin
                  // Single-cycle persistence: accept on first observation
                  level_d = s;
                  rise_d  = s;
                  fall_d  = ~s;
               end else begin
                  state_d = ST_CHANGING;
                  sc_d    = SC_ONE;
               end
            end
         end
         ST_CHANGING: begin
            if (s == level_q) begin
               state_d = ST_STABLE;
               sc_d    = '0;
            end else if (sc_q == SC_LAST) begin
               level_d = s;
               state_d = ST_STABLE;
               sc_d    = '0;
               rise_d  = s;
               fall_d  = ~s;
            end else begin
               sc_d = sc_q + SC_ONE;
            end
         end
         default: begin
            state_d = ST_STABLE;
            sc_d    = '0;
         end
      endcase
   end

   // Window timing, saturating edge count and result handshake
   always_comb begin
      terminal = (wcnt_q == WC_LAST);
      xfer     = cnt_valid_q & cnt_ready;
      ecnt_inc = (rise_q && (ecnt_q != CNT_MAX)) ? (ecnt_q + CNT_ONE) : ecnt_q;

      wcnt_d      = terminal ? '0 : (wcnt_q + WC_ONE);
      ecnt_d      = terminal ? '0 : ecnt_inc;
      cnt_data_d  = terminal ? ecnt_inc : cnt_data_q;

      cnt_valid_d = cnt_valid_q;
      cnt_ovf_d   = cnt_ovf_q;
      if (terminal) begin
         cnt_valid_d = 1'b1;
         // An unread result being replaced is flagged; a simultaneous
         // transfer means the old result was consumed, so the flag clears
         if (cnt_valid_q && !xfer) begin
            cnt_ovf_d = 1'b1;
         end else if (xfer) begin
            cnt_ovf_d = 1'b0;
         end
      end else if (xfer) begin
         cnt_valid_d = 1'b0;
         cnt_ovf_d   = 1'b0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q      <= '0;
         state_q     <= ST_STABLE;
         sc_q        <= '0;
         level_q     <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         wcnt_q      <= '0;
         ecnt_q      <= '0;
         cnt_data_q  <= '0;
         cnt_valid_q <= 1'b0;
         cnt_ovf_q   <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         sc_q        <= sc_d;
         level_q     <= level_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         wcnt_q      <= wcnt_d;
         ecnt_q      <= ecnt_d;
         cnt_data_q  <= cnt_data_d;
         cnt_valid_q <= cnt_valid_d;
         cnt_ovf_q   <= cnt_ovf_d;
      end
   end

   assign out_level  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign cnt_valid  = cnt_valid_q;
   assign cnt_data   = cnt_data_q;
   assign cnt_ovf    = cnt_ovf_q;

endmodule
`default_nettype wire
